// File: rtl/or_gate.sv
// or_gate: bitwise OR with a combinational result, a registered shadow,
// an any-bit-set flag and a saturating count of that flag's rising edges.
module or_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] y_q,
    output logic             any_q,
    output logic [CNT_W-1:0] rise_cnt
);
    logic any;
    assign y   = a | b;
    assign any = |y;
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q      <= '0;
            any_q    <= 1'b0;
            rise_cnt <= '0;
        end else begin
            y_q   <= y;
            any_q <= any;
            if (any && !any_q && !(&rise_cnt))
                rise_cnt <= rise_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_or_gate.sv
// tb_or_gate: truth-table vectors with the clock idle, then clocked
// sequences checked against a scoreboard fed by a behavioural model.
module tb_or_gate;
    logic clk = 1'b0, run = 1'b0, rst = 1'b1;
    logic a1, b1, y1, yq1, any1, yq2, any2, y2;
    logic [7:0] a8, b8, y8, yq8;
    logic any8;
    logic [15:0] c1, c8;
    logic [1:0] c2;
    int total = 0, fails = 0;

    always #5 if (run) clk = ~clk;

    or_gate #(.WIDTH(1), .CNT_W(16)) u1 (.a(a1), .b(b1), .y(y1), .clk(clk), .rst(rst),
        .y_q(yq1), .any_q(any1), .rise_cnt(c1));
    or_gate #(.WIDTH(8), .CNT_W(16)) u8 (.a(a8), .b(b8), .y(y8), .clk(clk), .rst(rst),
        .y_q(yq8), .any_q(any8), .rise_cnt(c8));
    or_gate #(.WIDTH(1), .CNT_W(2)) u2 (.a(a1), .b(b1), .y(y2), .clk(clk), .rst(rst),
        .y_q(yq2), .any_q(any2), .rise_cnt(c2));

    typedef struct packed {
        logic a, b, y;
        logic [7:0] a8, b8, y8;
    } vec_t;

    typedef struct packed {
        logic yq1, any1;
        logic [15:0] c1;
        logic [7:0] yq8;
        logic any8;
        logic [15:0] c8;
        logic yq2, any2;
        logic [1:0] c2;
    } exp_t;

    vec_t tt [6];
    exp_t sb [$];
    exp_t m = '0;
    exp_t e;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic step(input logic a, input logic b, input logic [7:0] ax, input logic [7:0] bx,
                        input logic r);
        logic n1, n8;
        @(negedge clk);
        a1 = a; b1 = b; a8 = ax; b8 = bx; rst = r;
        n1 = a | b;
        n8 = |(ax | bx);
        if (r) m = '0;
        else begin
            if (n1 && !m.any1 && m.c1 != 16'hFFFF) m.c1 = m.c1 + 16'd1;
            if (n8 && !m.any8 && m.c8 != 16'hFFFF) m.c8 = m.c8 + 16'd1;
            if (n1 && !m.any2 && m.c2 != 2'd3) m.c2 = m.c2 + 2'd1;
            m.yq1 = n1; m.any1 = n1; m.yq2 = n1; m.any2 = n1;
            m.yq8 = ax | bx; m.any8 = n8;
        end
        sb.push_back(m);
        #1;
        check("y_comb", {31'd0, y1}, {31'd0, n1});
        check("y8_comb", {24'd0, y8}, {24'd0, ax | bx});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("y_q", {31'd0, yq1}, {31'd0, e.yq1});
            check("any_q", {31'd0, any1}, {31'd0, e.any1});
            check("rise_cnt", {16'd0, c1}, {16'd0, e.c1});
            check("y_q8", {24'd0, yq8}, {24'd0, e.yq8});
            check("any_q8", {31'd0, any8}, {31'd0, e.any8});
            check("rise_cnt8", {16'd0, c8}, {16'd0, e.c8});
            check("y_q_c2", {31'd0, yq2}, {31'd0, e.yq2});
            check("any_q_c2", {31'd0, any2}, {31'd0, e.any2});
            check("rise_cnt_c2", {30'd0, c2}, {30'd0, e.c2});
        end
    endtask

    initial begin
        tt[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        tt[1] = '{1'b0, 1'b1, 1'b1, 8'hA0, 8'h05, 8'hA5};
        tt[2] = '{1'b1, 1'b0, 1'b1, 8'h0F, 8'hF0, 8'hFF};
        tt[3] = '{1'b1, 1'b1, 1'b1, 8'h55, 8'h55, 8'h55};
        tt[4] = '{1'bx, 1'b0, 1'bx, 8'h3C, 8'h81, 8'hBD};
        tt[5] = '{1'bx, 1'b1, 1'b1, 8'h00, 8'h01, 8'h01};
        for (int i = 0; i < 6; i++) begin
            a1 = tt[i].a; b1 = tt[i].b; a8 = tt[i].a8; b8 = tt[i].b8;
            #1;
            check("tt_y", {31'd0, y1}, {31'd0, tt[i].y});
            check("tt_y8", {24'd0, y8}, {24'd0, tt[i].y8});
            #9;
        end
        run = 1'b1;
        // reset then first operand
        step(0, 1, 8'hA0, 8'h05, 1);
        step(0, 1, 8'hA0, 8'h05, 1);
        step(0, 1, 8'hA0, 8'h05, 0);
        check("first_any_q", {31'd0, any1}, 32'd1);
        check("first_y_q8", {24'd0, yq8}, 32'hA5);
        // edge counting from a fresh reset
        step(0, 0, 8'h00, 8'h00, 1);
        step(0, 0, 8'h00, 8'h00, 0);
        step(1, 0, 8'h10, 8'h00, 0);
        step(0, 0, 8'h00, 8'h00, 0);
        step(1, 1, 8'h01, 8'h80, 0);
        step(0, 1, 8'h00, 8'h02, 0);
        check("edge_cnt_end", {16'd0, c1}, 32'd2);
        // saturation of the 2-bit counter
        step(0, 0, 8'h00, 8'h00, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 8'h01, 8'h00, 0);
            step(0, 0, 8'h00, 8'h00, 0);
        end
        check("sat_cnt", {30'd0, c2}, 32'd3);
        check("nosat_cnt", {16'd0, c1}, 32'd5);
        // reset mid-run with inputs held high
        step(1, 0, 8'hFF, 8'h00, 0);
        step(1, 0, 8'hFF, 8'h00, 1);
        check("rst_y_held", {31'd0, y1}, 32'd1);
        check("rst_cnt_clear", {16'd0, c1}, 32'd0);
        step(1, 0, 8'hFF, 8'h00, 0);
        check("rst_release_cnt", {16'd0, c1}, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, fails);
        $finish;
    end
endmodule

// File: doc/or_gate.md
Name: or_gate

Overview:
- Parameterisable bitwise 2-input OR gate with a purely combinational primary output `y`.
- Adds a registered shadow of the result, a registered "any bit set" flag and a saturating rising-edge event counter for downstream status/debug logic.
- Leaf cell in the basic-logic-gates library. It is usable as a plain OR gate via its first three ports only: `a`, `b`, `y`.

Parameters:
- WIDTH, 1, bit width of operands `a`, `b` and results `y`, `y_q`.
- CNT_W, 16, width of the event counter `rise_cnt`.

Ports:
- clk  input  1  system clock; all registered outputs update on its rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- y  output  WIDTH  combinational bitwise OR, a | b.
- y_q  output  WIDTH  registered copy of y.
- any_q  output  1  registered reduction-OR of y.
- rise_cnt  output  CNT_W  saturating count of any_q 0->1 transitions.

Port declaration order is fixed as a, b, y, clk, rst, y_q, any_q, rise_cnt. This keeps a three-port positional hookup (a, b, y) valid.

Behaviour:
- One clock (clk). Reset rst is synchronous and active-high.
- y:
  - y[i] = a[i] | b[i] for every bit i, with zero latency (continuous assignment).
  - No dependence on clk or rst; y is correct even with clk/rst unconnected.
- Truth table per bit: 0,0->0; 0,1->1; 1,0->1; 1,1->1.
- Unknown inputs: standard Verilog OR semantics. A 1 on either input forces 1; otherwise X/Z propagates as X. No special X handling.
- Registered outputs, on each rising clk edge:
  - rst=1: y_q <= 0, any_q <= 0, rise_cnt <= 0. This takes precedence over all other updates in that cycle.
  - rst=0:
    - y_q <= a | b.
    - any_q <= |(a | b).
    - If |(a | b) == 1 and any_q == 0, rise_cnt increments by 1. It saturates at all-ones (2^CNT_W - 1) and never wraps.
- Latency: y_q and any_q lag y by exactly one clock. rise_cnt reflects an edge in the same cycle that any_q rises.
- Reset mid-operation: all registered outputs clear on the next edge with rst=1. The first edge after rst deasserts samples fresh inputs. Rising-edge detection restarts from any_q=0, so an input already nonzero at reset release counts as one rise.
- Inputs changing between clock edges: only y follows them. Registered outputs sample only at edges; no glitch filtering.
- WIDTH=1: any_q equals y_q.

Test Plan:
- Combinational truth table, WIDTH=1, clk idle: a/b = 0/0, 0/1, 1/0, 1/1, each held 10 ns -> y = 0, 1, 1, 1 within the same timestep.
- Registered path: rst=1 for 2 cycles, then a=0,b=1 at cycle 3 -> y_q and any_q stay 0 through reset, become 1 one edge after cycle 3; rise_cnt = 1.
- Edge counting: toggle the inputs 0/0 -> 1/0 -> 0/0 -> 1/1 -> 0/1, one cycle each -> any_q = 0, 1, 0, 1, 1 (one cycle delayed); rise_cnt ends at 2.
- Saturation with CNT_W=2: produce 5 separate 0->1 pulses -> rise_cnt = 1, 2, 3, 3, 3.
- Reset mid-run: inputs held at a=1; assert rst for 1 cycle -> y stays 1 throughout; y_q, any_q, rise_cnt = 0 on the reset edge; next edge gives any_q=1 and rise_cnt=1.
- WIDTH=8: a=8'hA0, b=8'h05 -> y = 8'hA5 immediately, y_q = 8'hA5 next edge. a=b=8'h00 -> y = 8'h00, any_q = 0.
